// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//   Multi-cycle unsigned multiplier that yields the low N bits of op_a*op_b
//   (RV32M MUL). It has no adder of its own: each cycle of the shift-and-add
//   schedule it borrows the shared EX-stage ALU. While busy it drives the ALU
//   operands and select. Outside RUN it drives them to zero with an AND
//   select, so the ALU output sits at zero.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request a multiply (sampled in IDLE or DONE only)
//   flush      synchronous abort, wins over start
//   op_a/op_b  multiplicand / multiplier, captured on an accepted start
//   alu_a/alu_b/alu_sel  drive the shared ALU
//   alu_result combinational ALU output, consumed in the same cycle
//   busy       high while the schedule runs (N cycles)
//   done       one-cycle pulse when product is updated
//   product    registered result, held until the next completed multiply

module alu_mul_sequencer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         flush,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [N-1:0] alu_result,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] product
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_AND = 4'b0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_reg;
  logic [N-1:0]   acc_reg;
  logic [N-1:0]   mcand_reg;
  logic [N-1:0]   mplier_reg;
  logic [CW-1:0]  cnt_reg;
  logic [N-1:0]   product_reg;

  // Accumulator value after this cycle's partial product. The add itself is
  // performed by the external ALU; carries beyond bit N-1 are dropped there.
  logic [N-1:0]   acc_next;
  assign acc_next = mplier_reg[0] ? alu_result : acc_reg;

  // Everything below is decoded from registers only, so there is no
  // combinational path from start/op_* to any output.
  assign busy    = (state_reg == RUN);
  assign done    = (state_reg == DONE);
  assign alu_a   = busy ? acc_reg   : '0;
  assign alu_b   = busy ? mcand_reg : '0;
  assign alu_sel = busy ? SEL_ADD   : SEL_AND;
  assign product = product_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else if (flush) begin
      // Abort: drop the operation in flight, keep the last good product.
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            acc_reg    <= '0;
            mcand_reg  <= op_a;
            mplier_reg <= op_b;
            cnt_reg    <= '0;
            state_reg  <= RUN;
          end
        end

        RUN: begin
          // Fixed N iterations, no early exit when the multiplier empties,
          // so the pipeline sees a constant latency.
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            product_reg <= acc_next;
            state_reg   <= DONE;
          end
        end

        DONE: begin
          // A start here reloads directly for back-to-back operation.
          if (start) begin
            acc_reg    <= '0;
            mcand_reg  <= op_a;
            mplier_reg <= op_b;
            cnt_reg    <= '0;
            state_reg  <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;

  localparam int N = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          flush;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic [N-1:0]  alu_a;
  logic [N-1:0]  alu_b;
  logic [3:0]    alu_sel;
  logic [N-1:0]  alu_result;
  logic          busy;
  logic          done;
  logic [N-1:0]  product;

  int cmp_count  = 0;
  int fail_count = 0;

  logic [N-1:0] exp_q[$];

  localparam logic [N-1:0] CA [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678};
  localparam logic [N-1:0] CB [3] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0000};
  localparam logic [N-1:0] CE [3] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000};

  alu_mul_sequencer #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .flush      (flush),
    .op_a       (op_a),
    .op_b       (op_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .busy       (busy),
    .done       (done),
    .product    (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU model, purely combinational.
  always_comb begin
    alu_result = '0;
    case (alu_sel)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      default: alu_result = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one cycle; returns one cycle later (first RUN cycle).
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    tick();
    start = 1'b0;
  endtask

  // Cycles from the start cycle until done, bounded.
  task automatic wait_done(inout int lat);
    while (done !== 1'b1 && lat <= N + 10) begin
      tick();
      lat++;
    end
  endtask

  task automatic pop_exp(output logic [N-1:0] e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
    #3;
    cmp_count++; if ({busy, done} !== 2'b00) begin fail_count++; $display("FAIL reset_flags busy/done=%b required 00", {busy, done}); end
    cmp_count++; if (product !== '0) begin fail_count++; $display("FAIL reset_product got %h required 0", product); end
    cmp_count++; if ({alu_a, alu_b, alu_sel} !== '0) begin fail_count++; $display("FAIL reset_alu got a=%h b=%h sel=%b required 0", alu_a, alu_b, alu_sel); end
    #19 rst_n = 1'b1;
    tick();
    cmp_count++; if (busy !== 1'b0) begin fail_count++; $display("FAIL reset_idle busy=%b required 0", busy); end
    $display("reset: product=%h busy=%b done=%b", product, busy, done);
  endtask

  task automatic test_basic();
    logic [N-1:0] m_acc, m_mcand, m_mplier, e;
    m_acc = '0; m_mcand = 32'd6; m_mplier = 32'd7;
    exp_q.push_back(32'd42);
    launch(32'd6, 32'd7);
    for (int c = 1; c <= N; c++) begin
      cmp_count++; if ({busy, done} !== 2'b10) begin fail_count++; $display("FAIL basic_busy cycle %0d busy/done=%b required 10", c, {busy, done}); end
      cmp_count++; if (alu_sel !== 4'b0010) begin fail_count++; $display("FAIL basic_alu_sel cycle %0d got %b required 0010", c, alu_sel); end
      cmp_count++; if (alu_a !== m_acc || alu_b !== m_mcand) begin fail_count++; $display("FAIL basic_alu_ops cycle %0d got a=%h b=%h required a=%h b=%h", c, alu_a, alu_b, m_acc, m_mcand); end
      if (m_mplier[0]) m_acc = m_acc + m_mcand;
      m_mcand  = m_mcand << 1;
      m_mplier = m_mplier >> 1;
      tick();
    end
    pop_exp(e);
    cmp_count++; if ({busy, done} !== 2'b01) begin fail_count++; $display("FAIL basic_done cycle 33 busy/done=%b required 01", {busy, done}); end
    cmp_count++; if (product !== e) begin fail_count++; $display("FAIL basic_product got %h required %h", product, e); end
    cmp_count++; if ({alu_a, alu_b, alu_sel} !== '0) begin fail_count++; $display("FAIL basic_alu_quiet got a=%h b=%h sel=%b required 0", alu_a, alu_b, alu_sel); end
    $display("mul a=%h b=%h product=%h lat=%0d", 32'd6, 32'd7, product, N + 1);
    tick();
    cmp_count++; if ({busy, done} !== 2'b00) begin fail_count++; $display("FAIL basic_after cycle 34 busy/done=%b required 00", {busy, done}); end
  endtask

  task automatic test_flush();
    logic [N-1:0] e;
    e = 32'd42;
    launch(32'd9, 32'd9);
    for (int c = 1; c < 20; c++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cmp_count++; if ({busy, done} !== 2'b00) begin fail_count++; $display("FAIL flush_idle busy/done=%b required 00", {busy, done}); end
    cmp_count++; if (product !== e) begin fail_count++; $display("FAIL flush_product got %h required %h", product, e); end
    begin
      int pulses = 0;
      for (int c = 0; c < 20; c++) begin
        if (done === 1'b1 || busy === 1'b1) pulses++;
        tick();
      end
      cmp_count++; if (pulses !== 0) begin fail_count++; $display("FAIL flush_no_done got %0d active cycles required 0", pulses); end
    end
    start = 1'b1; flush = 1'b1; op_a = 32'd2; op_b = 32'd3;
    tick();
    start = 1'b0; flush = 1'b0;
    cmp_count++; if ({busy, done} !== 2'b00) begin fail_count++; $display("FAIL flush_start_idle busy/done=%b required 00", {busy, done}); end
    tick();
    cmp_count++; if ({busy, done} !== 2'b00) begin fail_count++; $display("FAIL flush_start_idle2 busy/done=%b required 00", {busy, done}); end
    $display("flush: product=%h busy=%b done=%b", product, busy, done);
  endtask

  task automatic test_corners();
    logic [N-1:0] e;
    for (int i = 0; i < 3; i++) begin
      int lat = 1;
      exp_q.push_back(CE[i]);
      launch(CA[i], CB[i]);
      wait_done(lat);
      pop_exp(e);
      cmp_count++; if (lat !== N + 1) begin fail_count++; $display("FAIL corner%0d_latency got %0d required %0d", i, lat, N + 1); end
      cmp_count++; if (product !== e) begin fail_count++; $display("FAIL corner%0d_product got %h required %h", i, product, e); end
      $display("mul a=%h b=%h product=%h lat=%0d", CA[i], CB[i], product, lat);
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] e;
    int dcount = 0;
    int dcyc = 0;
    int lat = 1;
    exp_q.push_back(32'd42);
    launch(32'd6, 32'd7);
    for (int c = 1; c <= N + 1; c++) begin
      if (done === 1'b1) begin dcount++; dcyc = c; end
      if (c == 10) begin start = 1'b1; op_a = 32'd1; op_b = 32'd1; end
      else if (c == 11) start = 1'b0;
      if (c < N + 1) tick();
    end
    pop_exp(e);
    cmp_count++; if (dcount !== 1 || dcyc !== N + 1) begin fail_count++; $display("FAIL ignore_start got %0d done pulses last at %0d required 1 at %0d", dcount, dcyc, N + 1); end
    cmp_count++; if (product !== e) begin fail_count++; $display("FAIL ignore_start_product got %h required %h", product, e); end
    $display("mul a=%h b=%h product=%h lat=%0d", 32'd6, 32'd7, product, dcyc);
    exp_q.push_back(32'd15);
    launch(32'd3, 32'd5);
    cmp_count++; if (busy !== 1'b1) begin fail_count++; $display("FAIL b2b_busy got %b required 1", busy); end
    wait_done(lat);
    pop_exp(e);
    cmp_count++; if (lat !== N + 1) begin fail_count++; $display("FAIL b2b_latency got %0d required %0d", lat, N + 1); end
    cmp_count++; if (product !== e) begin fail_count++; $display("FAIL b2b_product got %h required %h", product, e); end
    $display("mul a=%h b=%h product=%h lat=%0d", 32'd3, 32'd5, product, lat);
    tick();
  endtask

  task automatic test_async_reset();
    logic [N-1:0] e;
    int lat = 1;
    launch(32'd5, 32'd5);
    for (int c = 1; c < 6; c++) tick();
    #2 rst_n = 1'b0;
    #1;
    cmp_count++; if ({busy, done} !== 2'b00) begin fail_count++; $display("FAIL arst_flags busy/done=%b required 00", {busy, done}); end
    cmp_count++; if (product !== '0) begin fail_count++; $display("FAIL arst_product got %h required 0", product); end
    cmp_count++; if ({alu_a, alu_b, alu_sel} !== '0) begin fail_count++; $display("FAIL arst_alu got a=%h b=%h sel=%b required 0", alu_a, alu_b, alu_sel); end
    tick();
    #2 rst_n = 1'b1;
    tick();
    cmp_count++; if ({busy, done} !== 2'b00) begin fail_count++; $display("FAIL arst_release busy/done=%b required 00", {busy, done}); end
    exp_q.push_back(32'd10000);
    launch(32'd100, 32'd100);
    wait_done(lat);
    pop_exp(e);
    cmp_count++; if (lat !== N + 1) begin fail_count++; $display("FAIL arst_latency got %0d required %0d", lat, N + 1); end
    cmp_count++; if (product !== e) begin fail_count++; $display("FAIL arst_product_after got %h required %h", product, e); end
    $display("mul a=%h b=%h product=%h lat=%0d", 32'd100, 32'd100, product, lat);
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, e;
    for (int i = 0; i < 1000; i++) begin
      int lat = 1;
      a = $urandom;
      b = (i % 8 == 0) ? N'($urandom_range(0, 255)) : N'($urandom);
      exp_q.push_back(a * b);
      launch(a, b);
      wait_done(lat);
      pop_exp(e);
      cmp_count++; if (product !== e || lat !== N + 1) begin fail_count++; $display("FAIL random%0d got %h lat %0d required %h lat %0d", i, product, lat, e, N + 1); end
      $display("mul a=%h b=%h product=%h lat=%0d", a, b, product, lat);
      // Launch the next one straight out of DONE; every other run goes via IDLE.
      if (i % 2 == 1) tick();
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_corners();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle sequencer that computes the low N bits of an unsigned N×N multiply (RV32M MUL semantics) by driving the existing shared N-bit ALU through a shift-and-add schedule. It sits in the EX stage beside the ALU and owns the ALU operand/select inputs while busy. The pipeline stalls on `busy` and retires on `done`. No adder of its own: every accumulate goes through the ALU add path.

## Interface
- N, 32, datapath width; ≥ 2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request new multiply; sampled only in IDLE or DONE
- flush  in  1  synchronous abort (pipeline flush); priority over start
- op_a  in  N  multiplicand, captured on accepted start
- op_b  in  N  multiplier, captured on accepted start
- alu_a  out  N  to ALU operand A
- alu_b  out  N  to ALU operand B
- alu_sel  out  4  to ALU select
- alu_result  in  N  from ALU output (combinational, same cycle)
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse, high in DONE
- product  out  N  registered result, low N bits of op_a×op_b

## Operation
- States: IDLE, RUN, DONE.
- Internal regs: acc[N], mcand[N], mplier[N], cnt[ceil(log2 N)], product[N].
- IDLE: start=1 and flush=0 → acc←0, mcand←op_a, mplier←op_b, cnt←0, go to RUN.
- RUN, every cycle:
  - Drive alu_a=acc, alu_b=mcand, alu_sel=4'b0010 (add).
  - If mplier[0]=1, acc←alu_result; else acc holds.
  - mcand←mcand<<1, zero fill.
  - mplier←mplier>>1, zero fill.
  - cnt←cnt+1.
- RUN, cnt=N-1: product←final acc value (alu_result if mplier[0], else acc), go to DONE.
- DONE: done=1. start=1 → reload exactly as in IDLE and go to RUN (back-to-back); otherwise go to IDLE.
- start during RUN: ignored, no queuing.
- flush=1 in any state: next state IDLE, product unchanged, done not asserted. If flush and start are both high, flush wins.
- Arithmetic: all modulo 2^N. Carries out of the ALU are discarded, so the result equals (op_a×op_b) mod 2^N. Signedness is irrelevant for the low half.
- Fixed latency: no early termination when mplier reaches 0.
- Outside RUN: alu_a=0, alu_b=0, alu_sel=4'b0000 (AND → 0), so the ALU sits quiet.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, product=0, alu_a=0, alu_b=0, alu_sel=0; acc, mcand, mplier, cnt=0.
- Reset mid-operation aborts immediately; no done pulse follows.
- start high in cycle 0 (IDLE):
  - busy=1 in cycles 1..N.
  - product valid and done=1 in cycle N+1.
  - Total start-to-done latency N+1 cycles.
- Back-to-back: start in the DONE cycle N+1 → RUN in cycles N+2..2N+1, second done in cycle 2N+2. Throughput is one result per N+1 cycles.
- busy, done, alu_* are decoded from registered state only. No combinational path from start or op_* to any output.
- product holds its value until the next completed multiply or reset.
- alu_result is consumed in the same cycle alu_a/alu_b are driven. The ALU path must close within one clock.

## Test plan
- Reset, then start with op_a=6, op_b=7 (N=32) in cycle 0 → busy cycles 1–32; done=1 only in cycle 33 with product=42; done=0 in cycle 34.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF → product=0x00000001. op_a=0x80000000, op_b=2 → product=0. op_a=0x12345678, op_b=0 → product=0, still 33-cycle latency.
- Pulse start again at cycle 10 during RUN → ignored; single done at cycle 33. Then start in the DONE cycle with 3×5 → second done at cycle 66, product=15.
- Flush at cycle 20 of a 9×9 run, after a prior result of 42 → IDLE at cycle 21, busy=0, no done, product stays 42. Flush and start together in IDLE → stays IDLE.
- Assert rst_n=0 asynchronously mid-RUN → all outputs 0 immediately. After release, 100×100 completes with product=10000.
- During RUN, alu_sel=4'b0010 and alu_a/alu_b track acc/mcand each cycle. In IDLE/DONE all alu_* are 0. Random 1000-vector check against (a*b) mod 2^32.
